display_scan_mux: RTL

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_scan_mux_if.sv | 22 ++
 rtl/display_scan_mux.sv | 82 ++++++++
 2 files changed

// File: rtl/display_scan_mux_if.sv
// Display-side bus for display_scan_mux: digit patterns and enables in,
// multiplexed anode/segment drive and frame marker out.
interface display_scan_mux_if #(
  parameter int DIGITS = 4,
  parameter int SEG_W  = 7
);
  logic [DIGITS*SEG_W-1:0] ivDigits;
  logic [DIGITS-1:0]       ivDigitEn;
  logic [DIGITS-1:0]       ovAnode;
  logic [SEG_W-1:0]        ovDisplay;
  logic                    oFrame;

  modport master (
    output ivDigits, ivDigitEn,
    input  ovAnode, ovDisplay, oFrame
  );

  modport slave (
    input  ivDigits, ivDigitEn,
    output ovAnode, ovDisplay, oFrame
  );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed seven-segment scanner: per-digit slot of PRESCALE enabled
// cycles, BLANK dead-time cycles first, registered one-cold active-low anodes.
module display_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SEG_W    = 7,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic                iCE,
  display_scan_mux_if.slave   bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]     cnt, cntNext;
  logic [IW-1:0]     idx, idxNext;
  logic              inShow, showNext, load;
  logic [SEG_W-1:0]  snapSeg, segNext;
  logic              snapEn, enNext;
  logic [DIGITS-1:0] anodeReg;
  logic [SEG_W-1:0]  displayReg;
  logic              frameReg;

  always_comb begin
    cntNext = cnt + 1'b1;
    idxNext = idx;
    if (cnt == CW'(PRESCALE - 1)) begin
      cntNext = '0;
      idxNext = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  generate
    if (BLANK == 0) begin : gNoBlank
      assign showNext = 1'b1;
    end else begin : gBlank
      assign showNext = (cntNext >= CW'(BLANK));
    end
  endgenerate

  // Snapshot on entry to SHOW; inShow also catches the first post-reset
  // edge when BLANK=0, where the slot start was consumed by reset.
  always_comb begin
    load    = showNext && (!inShow || (cntNext == CW'(BLANK)));
    segNext = snapSeg;
    enNext  = snapEn;
    if (load) begin
      segNext = bus.ivDigits[idxNext*SEG_W +: SEG_W];
      enNext  = bus.ivDigitEn[idxNext];
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt        <= '0;
      idx        <= '0;
      inShow     <= 1'b0;
      snapSeg    <= '0;
      snapEn     <= 1'b0;
      anodeReg   <= '1;
      displayReg <= '0;
      frameReg   <= 1'b0;
    end else if (iCE) begin
      cnt        <= cntNext;
      idx        <= idxNext;
      inShow     <= showNext;
      snapSeg    <= segNext;
      snapEn     <= enNext;
      anodeReg   <= (showNext && enNext) ? ~(DIGITS'(1) << idxNext) : '1;
      displayReg <= (showNext && enNext) ? segNext : '0;
      frameReg   <= load && (idxNext == '0);
    end else begin
      frameReg   <= 1'b0;
    end
  end

  assign bus.ovAnode   = anodeReg;
  assign bus.ovDisplay = displayReg;
  assign bus.oFrame    = frameReg;
endmodule
